// File: rtl/glyph_fetcher.sv
// glyph_fetcher: walks a text console cell by cell, fetching each character's code, colours and glyph
// shape and offering the cell to a downstream renderer. Optional cursor highlight: define GLYPH_CURSOR_EN.
module glyph_fetcher #(
   parameter int COLUMNS = 80,
   parameter int ROWS    = 30,
   parameter int CHAR_W  = 8,
   parameter int CHAR_H  = 16,
   parameter int COLOR_W = 8,
   localparam int TA_W    = $clog2(COLUMNS*ROWS),
   localparam int ROW_W   = $clog2(ROWS),
   localparam int COL_W   = $clog2(COLUMNS),
   localparam int ADDR_W  = $clog2(COLUMNS*ROWS*CHAR_W*CHAR_H),
   localparam int SHAPE_W = CHAR_W*CHAR_H,
   localparam int TEXT_W  = 8 + 2*COLOR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic               frame_done,
   output logic [TA_W-1:0]    text_addr,
   output logic               text_re,
   input  logic [TEXT_W-1:0]  text_rdata,
   output logic [7:0]         font_addr,
   output logic               font_re,
   input  logic [SHAPE_W-1:0] font_rdata,
   output logic [SHAPE_W-1:0] grid_shape,
   output logic [COLOR_W-1:0] grid_fg,
   output logic [COLOR_W-1:0] grid_bg,
   output logic [ADDR_W-1:0]  base_address,
   output logic               font_ready,
   input  logic               render_done,
   input  logic [ROW_W-1:0]   cursor_row,
   input  logic [COL_W-1:0]   cursor_col,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ_TEXT = 3'd1,
      READ_FONT = 3'd2,
      OFFER     = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam int ROW_STRIDE = COLUMNS*CHAR_W*CHAR_H;

   state_t             r_state;
   logic               r_phase;
   logic [ROW_W-1:0]   r_row;
   logic [COL_W-1:0]   r_col;
   logic [COLOR_W-1:0] r_fg;
   logic [COLOR_W-1:0] r_bg;
   logic               r_busy;
   logic               r_frame_done;
   logic [TA_W-1:0]    r_text_addr;
   logic               r_text_re;
   logic [7:0]         r_font_addr;
   logic               r_font_re;
   logic [SHAPE_W-1:0] r_grid_shape;
   logic [COLOR_W-1:0] r_grid_fg;
   logic [COLOR_W-1:0] r_grid_bg;
   logic [ADDR_W-1:0]  r_base_address;
   logic               r_font_ready;

   logic               w_last_col;
   logic               w_last_row;
   logic [ROW_W-1:0]   w_next_row;
   logic [COL_W-1:0]   w_next_col;
   logic [TA_W-1:0]    w_next_addr;
   logic [ADDR_W-1:0]  w_base;
   logic [COLOR_W-1:0] w_fg_sel;
   logic [COLOR_W-1:0] w_bg_sel;

   assign w_last_col  = (r_col == COL_W'(COLUMNS - 1));
   assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
   assign w_next_addr = TA_W'(w_next_row) * TA_W'(COLUMNS) + TA_W'(w_next_col);
   // Widened to the full SRAM address before multiplying so no partial product is truncated.
   assign w_base      = ADDR_W'(r_row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(r_col) * ADDR_W'(CHAR_W);

   always_comb begin
      w_next_row = r_row;
      w_next_col = r_col + 1'b1;
      if (w_last_col) begin
         w_next_col = '0;
         w_next_row = r_row + 1'b1;
      end
   end

`ifdef GLYPH_CURSOR_EN
   logic r_cursor_hit;
   assign w_fg_sel = r_cursor_hit ? r_bg : r_fg;
   assign w_bg_sel = r_cursor_hit ? r_fg : r_bg;
`else
   logic w_unused_cursor;
   assign w_unused_cursor = ^{cursor_row, cursor_col};
   assign w_fg_sel = r_fg;
   assign w_bg_sel = r_bg;
`endif

   // Handshake: font_ready is the valid for the offered cell and render_done is its ready; the cell
   // transfers on the first cycle both are high, and font_ready is never withdrawn before that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_phase        <= 1'b0;
         r_row          <= '0;
         r_col          <= '0;
         r_fg           <= '0;
         r_bg           <= '0;
         r_busy         <= 1'b0;
         r_frame_done   <= 1'b0;
         r_text_addr    <= '0;
         r_text_re      <= 1'b0;
         r_font_addr    <= '0;
         r_font_re      <= 1'b0;
         r_grid_shape   <= '0;
         r_grid_fg      <= '0;
         r_grid_bg      <= '0;
         r_base_address <= '0;
         r_font_ready   <= 1'b0;
`ifdef GLYPH_CURSOR_EN
         r_cursor_hit   <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_row       <= '0;
                  r_col       <= '0;
                  r_text_addr <= '0;
                  r_text_re   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_phase     <= 1'b0;
                  r_state     <= READ_TEXT;
               end
            end
            READ_TEXT: begin
               // r_phase 0 is the strobe cycle, 1 is the cycle the memory data is captured.
               if (!r_phase) begin
                  r_text_re <= 1'b0;
                  r_phase   <= 1'b1;
`ifdef GLYPH_CURSOR_EN
                  r_cursor_hit <= (r_row == cursor_row) && (r_col == cursor_col);
`endif
               end else begin
                  r_font_addr <= text_rdata[TEXT_W-1 -: 8];
                  r_fg        <= text_rdata[2*COLOR_W-1 -: COLOR_W];
                  r_bg        <= text_rdata[COLOR_W-1:0];
                  r_font_re   <= 1'b1;
                  r_phase     <= 1'b0;
                  r_state     <= READ_FONT;
               end
            end
            READ_FONT: begin
               if (!r_phase) begin
                  r_font_re <= 1'b0;
                  r_phase   <= 1'b1;
               end else begin
                  r_grid_shape   <= font_rdata;
                  r_grid_fg      <= w_fg_sel;
                  r_grid_bg      <= w_bg_sel;
                  r_base_address <= w_base;
                  r_font_ready   <= 1'b1;
                  r_phase        <= 1'b0;
                  r_state        <= OFFER;
               end
            end
            OFFER: begin
               if (render_done) begin
                  r_font_ready <= 1'b0;
                  r_state      <= HOLD;
               end
            end
            HOLD: begin
               if (w_last_col && w_last_row) begin
                  r_row        <= '0;
                  r_col        <= '0;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= IDLE;
               end else begin
                  r_row       <= w_next_row;
                  r_col       <= w_next_col;
                  r_text_addr <= w_next_addr;
                  r_text_re   <= 1'b1;
                  r_state     <= READ_TEXT;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_phase      <= 1'b0;
               r_busy       <= 1'b0;
               r_text_re    <= 1'b0;
               r_font_re    <= 1'b0;
               r_font_ready <= 1'b0;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign text_addr    = r_text_addr;
   assign text_re      = r_text_re;
   assign font_addr    = r_font_addr;
   assign font_re      = r_font_re;
   assign grid_shape   = r_grid_shape;
   assign grid_fg      = r_grid_fg;
   assign grid_bg      = r_grid_bg;
   assign base_address = r_base_address;
   assign font_ready   = r_font_ready;
   assign dbg_state    = r_state;

endmodule

// File: doc/glyph_fetcher.md
GLYPH_FETCHER -- requirements
Module: glyph_fetcher

Interface
REQ-001 SHALL have parameter COLUMNS, 80, console character columns.
REQ-002 SHALL have parameter ROWS, 30, console character rows.
REQ-003 SHALL have parameter CHAR_W, 8, glyph width in pixels.
REQ-004 SHALL have parameter CHAR_H, 16, glyph height in pixels.
REQ-005 SHALL have parameter COLOR_W, 8, colour / SRAM pixel width.
REQ-006 SHALL have ports: clk in 1, sole clock; rst_n in 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports: start in 1, frame-pass request pulse; busy out 1, pass in progress; frame_done out 1, one-cycle pulse at end of pass.
REQ-008 SHALL have ports: text_addr out clog2(COLUMNS*ROWS), text-buffer cell index; text_re out 1, read strobe; text_rdata in 8+2*COLOR_W, {code[7:0], fg, bg}.
REQ-009 SHALL have ports: font_addr out 8, glyph code; font_re out 1, read strobe; font_rdata in CHAR_W*CHAR_H, shape, MSB = top-left pixel.
REQ-010 SHALL have ports: grid_shape out CHAR_W*CHAR_H; grid_fg out COLOR_W; grid_bg out COLOR_W; base_address out SRAM address width, first pixel of cell.
REQ-011 SHALL have ports: font_ready out 1, grid offered; render_done in 1, downstream renderer idle/finished.
REQ-012 SHALL have ports: cursor_row in clog2(ROWS); cursor_col in clog2(COLUMNS).

Function
REQ-013 SHALL implement states IDLE, READ_TEXT, READ_FONT, OFFER, HOLD.
REQ-014 IDLE: start=1 -> row=0, col=0, READ_TEXT; start ignored outside IDLE.
REQ-015 READ_TEXT: text_re=1 for exactly one cycle with text_addr=row*COLUMNS+col; text_rdata valid and captured on the following cycle.
REQ-016 READ_FONT: font_re=1 for one cycle with font_addr=captured code; font_rdata captured next cycle into grid_shape, fg/bg into grid_fg/grid_bg; then OFFER.
REQ-017 base_address SHALL equal row*COLUMNS*CHAR_W*CHAR_H + col*CHAR_W, computed full-width, no truncation before output width.
REQ-018 OFFER: font_ready=1 level; acceptance = font_ready & render_done in same cycle -> HOLD.
REQ-019 HOLD: font_ready=0; grid_*, base_address unchanged for this cycle (renderer latches here); then advance cell.
REQ-020 Advance: col+1; at col=COLUMNS-1 wrap col=0, row+1; at last cell (ROWS-1, COLUMNS-1) -> frame_done pulse one cycle, IDLE, row/col=0.
REQ-021 grid_*, base_address SHALL be stable from entering OFFER through HOLD inclusive.
REQ-022 busy=1 in every state except IDLE; frame_done coincides with the IDLE transition cycle.
REQ-023 render_done high outside OFFER SHALL have no effect; render_done low in OFFER -> stay, font_ready held.
REQ-024 Per-cell latency start/advance to font_ready SHALL be exactly 4 cycles (READ_TEXT, capture, READ_FONT, capture).

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, row=col=0, busy=0, frame_done=0, font_ready=0, text_re=0, font_re=0, grid_* =0, base_address=0.
REQ-026 Reset mid-pass SHALL abandon the pass with no frame_done; operation resumes only on a new start after rst_n rises.

Configuration
REQ-027 Macro GLYPH_CURSOR_EN defined: cell with row==cursor_row and col==cursor_col SHALL be offered with grid_fg/grid_bg swapped; cursor sampled at READ_TEXT.
REQ-028 GLYPH_CURSOR_EN undefined: cursor_row/cursor_col ignored, colours passed unchanged.

Verification
REQ-029 Reset then start, render_done tied 1, COLUMNS=4, ROWS=2 -> 8 offers, text_addr 0..7 in order, frame_done once after 8th HOLD, busy falls same cycle.
REQ-030 Cell (1,2), COLUMNS=80, CHAR_W=8, CHAR_H=16 -> base_address=1*80*128+16=10256.
REQ-031 text_rdata={0x41,0x0F,0x01}, font_rdata=0x8000...0 -> font_addr=0x41, grid_shape MSB=1, grid_fg=0x0F, grid_bg=0x01.
REQ-032 render_done held 0 for 10 cycles in OFFER -> font_ready stays 1, outputs constant; render_done=1 -> HOLD next cycle, font_ready=0.
REQ-033 rst_n pulsed low in READ_FONT of cell 3 -> all outputs 0 immediately, no frame_done; new start begins at text_addr=0.
REQ-034 GLYPH_CURSOR_EN, cursor=(0,1), fg=0x0F, bg=0x01 -> cell 1 offers fg=0x01, bg=0x0F; cells 0, 2 unswapped.
